// File: rtl/pixel_packer.sv
// Packs pairs of 8x16-bit lane beats into 128-bit words of saturated 8-bit pixels,
// with flush of partial words, byte enables and wrapping word addresses.
module pixel_packer #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic [15:0]       out_mask,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              sat
);

  // state | meaning
  // IDLE  | nothing held
  // HALF  | low half (bytes 0-7) held in half_q
  // OUT   | word presented on out_*, waiting for handshake
  typedef enum logic [1:0] {IDLE, HALF, OUT} state_t;

  state_t      state, state_nxt;
  logic [63:0] half_q;
  logic [63:0] pix;
  logic        lane_sat;
  logic        flush_pend;
  logic        pend_eff;
  logic        accept;
  logic        store_half, load_full, load_part, clear_pend;

  always_comb begin
    pix      = '0;
    lane_sat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_data[16*i+8 +: 8] == 8'h00) begin
        pix[8*i +: 8] = in_data[16*i +: 8];
      end else begin
        pix[8*i +: 8] = 8'hFF;
        lane_sat      = 1'b1;
      end
    end
  end

  assign out_valid = (state == OUT);
  assign in_ready  = rst_n && ((state != OUT) || out_ready);
  assign accept    = in_valid && in_ready;
  // A flush seen this cycle acts immediately, so a partial word follows in the next cycle.
  assign pend_eff  = flush_pend || flush;

  always_comb begin
    state_nxt  = state;
    store_half = 1'b0;
    load_full  = 1'b0;
    load_part  = 1'b0;
    clear_pend = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          store_half = 1'b1;
          state_nxt  = HALF;
        end else if (pend_eff) begin
          clear_pend = 1'b1;
        end
      end
      HALF: begin
        if (accept) begin
          load_full = 1'b1;
          state_nxt = OUT;
        end else if (pend_eff) begin
          load_part = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (accept) begin
            store_half = 1'b1;
            state_nxt  = HALF;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      half_q     <= '0;
      out_data   <= '0;
      out_mask   <= '0;
      out_addr   <= BASE_ADDR;
      done       <= 1'b0;
      sat        <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= pend_eff && !clear_pend;
      done       <= clear_pend;
      if (store_half) half_q <= pix;
      if (load_full) begin
        out_data <= {pix, half_q};
        out_mask <= 16'hFFFF;
      end else if (load_part) begin
        out_data <= {64'h0, half_q};
        out_mask <= 16'h00FF;
      end
      if (out_valid && out_ready) out_addr <= out_addr + ADDR_W'(1);
      if (accept && lane_sat) sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Randomized scoreboard bench for pixel_packer; a pixel-list reference model
// predicts words, masks, addresses, sat and done pulses.
module tb_pixel_packer;

  localparam int               AW   = 4;
  localparam logic [AW-1:0]    BASE = 4'd14;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic [15:0]    out_mask;
  logic [AW-1:0]  out_addr;
  logic           done;
  logic           sat;

  pixel_packer #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask), .out_addr(out_addr),
    .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  mask;
  } word_t;

  word_t         q[$];
  logic [63:0]   held;
  bit            have_half;
  logic [AW-1:0] addr_cnt;
  bit            sat_exp;
  int            checks = 0;
  int            failures = 0;
  int            beats_acc = 0;
  int            done_seen = 0;
  int            done_exp = 0;
  int            rst_seen = 0;
  bit            rand_rdy = 1'b0;
  logic          ready_val = 1'b1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] conv(input logic [127:0] d, output bit s);
    logic [63:0] p;
    int v;
    p = '0;
    s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = int'(d[16*i +: 16]);
      if (v > 255) begin
        p[8*i +: 8] = 8'd255;
        s = 1'b1;
      end else begin
        p[8*i +: 8] = 8'(v);
      end
    end
    return p;
  endfunction

  function automatic logic [127:0] rand_beat(input bit allow_sat);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) begin
      if (allow_sat && $urandom_range(0, 15) == 0) d[16*i +: 16] = 16'($urandom_range(256, 65535));
      else d[16*i +: 16] = 16'($urandom_range(0, 255));
    end
    return d;
  endfunction

  // Reference model and monitor, sampled on the falling edge between drive points.
  always @(negedge clk) begin
    word_t w;
    bit    s;
    logic [63:0] g;
    if (!rst_n) begin
      chk(in_ready == 1'b0, "in_ready_in_reset", 128'(in_ready), 128'h0);
      if (rst_seen > 0) begin
        chk(out_valid == 1'b0, "rst_out_valid", 128'(out_valid), 128'h0);
        chk(out_addr == BASE, "rst_out_addr", 128'(out_addr), 128'(BASE));
        chk(sat == 1'b0 && done == 1'b0, "rst_sat_done", {sat, done}, 128'h0);
        chk(out_mask == 16'h0 && out_data == '0, "rst_out_regs", {out_mask, out_data[111:0]}, 128'h0);
      end
      rst_seen++;
      q.delete();
      have_half = 1'b0;
      addr_cnt  = BASE;
      sat_exp   = 1'b0;
    end else begin
      rst_seen = 0;
      chk(sat == sat_exp, "sat", 128'(sat), 128'(sat_exp));
      if (done) begin
        done_seen++;
        chk(q.size() == 0 && !have_half, "done_after_drain", 128'(q.size()), 128'h0);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_word", out_data, 128'h0);
        end else begin
          chk(out_data == q[0].data, "out_data", out_data, q[0].data);
          chk(out_mask == q[0].mask, "out_mask", 128'(out_mask), 128'(q[0].mask));
          chk(out_addr == addr_cnt, "out_addr", 128'(out_addr), 128'(addr_cnt));
          if (out_ready) begin
            w = q.pop_front();
            addr_cnt = addr_cnt + 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        g = conv(in_data, s);
        if (s) sat_exp = 1'b1;
        beats_acc++;
        if (have_half) begin
          q.push_back('{data: {g, held}, mask: 16'hFFFF});
          have_half = 1'b0;
        end else begin
          held      = g;
          have_half = 1'b1;
        end
      end
      if (flush && have_half) begin
        q.push_back('{data: {64'h0, held}, mask: 16'h00FF});
        have_half = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : ready_val;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [127:0] d, input bit fl);
    int start;
    int n;
    start    = beats_acc;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    do begin
      step();
      flush = 1'b0;
      n++;
    end while (beats_acc == start && n < 500);
    in_valid = 1'b0;
    if (beats_acc == start) chk(1'b0, "beat_accept_timeout", 128'(n), 128'h0);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_seen < done_exp && n < 500) begin
      step();
      n++;
    end
    if (done_seen < done_exp) chk(1'b0, "done_timeout", 128'(done_seen), 128'(done_exp));
  endtask

  task automatic drain();
    int n;
    n        = 0;
    rand_rdy = 1'b0;
    ready_val = 1'b1;
    while (q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    if (q.size() != 0) chk(1'b0, "drain_timeout", 128'(q.size()), 128'h0);
  endtask

  initial begin
    logic [127:0] a, b;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Known pair: bytes 01..10h, first address BASE.
    for (int i = 0; i < 8; i++) begin
      a[16*i +: 16] = 16'(i + 1);
      b[16*i +: 16] = 16'(i + 9);
    end
    send_beat(a, 1'b0);
    send_beat(b, 1'b0);
    chk(out_valid == 1'b1, "latency_out_valid", 128'(out_valid), 128'h1);
    chk(out_data == 128'h100F0E0D0C0B0A090807060504030201, "first_word", out_data,
        128'h100F0E0D0C0B0A090807060504030201);
    drain();

    // Flush with nothing held: done only.
    flush_pulse();
    done_exp++;
    wait_done();

    // Single beat then flush: partial word, then done.
    send_beat(rand_beat(1'b0), 1'b0);
    flush_pulse();
    done_exp++;
    wait_done();

    // Flush coinciding with the pairing beat: full word only.
    send_beat(rand_beat(1'b0), 1'b0);
    send_beat(rand_beat(1'b0), 1'b1);
    done_exp++;
    wait_done();

    // Repeated flushes while the partial word is stalled merge into one done.
    ready_val = 1'b0;
    send_beat(rand_beat(1'b0), 1'b0);
    flush_pulse();
    repeat (3) step();
    flush_pulse();
    repeat (2) step();
    flush_pulse();
    ready_val = 1'b1;
    done_exp++;
    wait_done();
    repeat (4) step();
    chk(done_seen == done_exp, "done_merge_count", 128'(done_seen), 128'(done_exp));

    // Saturating lane, then sticky over clean beats.
    a = rand_beat(1'b0);
    a[31:16] = 16'h0123;
    send_beat(a, 1'b0);
    send_beat(rand_beat(1'b0), 1'b0);
    drain();
    chk(sat == 1'b1, "sat_set", 128'(sat), 128'h1);
    send_beat(rand_beat(1'b0), 1'b0);
    send_beat(rand_beat(1'b0), 1'b0);
    drain();
    chk(sat == 1'b1, "sat_sticky", 128'(sat), 128'h1);

    // Random streaming with random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) step();
      send_beat(rand_beat(1'b1), 1'b0);
    end
    drain();

    // Back-to-back: one beat per cycle with ready held high.
    begin
      int start_b;
      int start_t;
      start_b = beats_acc;
      start_t = checks;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
        in_data = rand_beat(1'b1);
        step();
      end
      in_valid = 1'b0;
      chk(beats_acc - start_b == 20, "throughput_beats", 128'(beats_acc - start_b), 128'd20);
      drain();
    end

    // Reset while a word is stalled in OUT.
    ready_val = 1'b0;
    send_beat(rand_beat(1'b0), 1'b0);
    send_beat(rand_beat(1'b0), 1'b0);
    repeat (2) step();
    in_valid = 1'b1;
    in_data  = rand_beat(1'b0);
    rst_n    = 1'b0;
    repeat (2) step();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    ready_val = 1'b1;
    step();
    send_beat(rand_beat(1'b0), 1'b0);
    send_beat(rand_beat(1'b0), 1'b0);
    drain();
    chk(out_addr == BASE + 4'd1, "post_reset_addr", 128'(out_addr), 128'(BASE + 4'd1));

    repeat (5) step();
    chk(done_seen == done_exp, "done_total", 128'(done_seen), 128'(done_exp));
    chk(q.size() == 0, "queue_empty", 128'(q.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
